cmp_seq_ctrl: RTL

Sequencer that performs an N-nibble unsigned magnitude compare using one shared comparator4 instance. It walks the latched operands one nibble per cycle, MSB nibble first, and stops at the first unequal nibble. It sits beside the 8-bit ALU datapath and provides its compare/flag path with a start/busy/done handshake. All cascade combining is done here; the comparator4 cascade inputs are tied to eq=1, gt=0, lt=0 and their state is not relied upon.

---
 rtl/cmp_seq_pkg.sv | 20 ++
 rtl/comparator4.sv | 30 +++
 rtl/cmp_seq_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/cmp_seq_pkg.sv
// Shared types and helpers for the nibble-serial magnitude compare sequencer.
package cmp_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_e;

    // Width of the nibble index register: clog2(n), never less than one bit.
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/comparator4.sv
// 4-bit unsigned magnitude comparator with cascade inputs; on equal nibbles
// the cascade inputs are passed through.
module comparator4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       eq_in,
    input  logic       gt_in,
    input  logic       lt_in,
    output logic       eq,
    output logic       gt,
    output logic       lt
);

    // Nibble compare, deferring to the cascade when the nibbles match.
    always_comb begin
        eq = 1'b0;
        gt = 1'b0;
        lt = 1'b0;
        if (a > b) begin
            gt = 1'b1;
        end else if (a < b) begin
            lt = 1'b1;
        end else begin
            eq = eq_in;
            gt = gt_in;
            lt = lt_in;
        end
    end

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Walks two latched operands MSB nibble first through one shared comparator4,
// stopping at the first unequal nibble, with a start/busy/done handshake.
module cmp_seq_ctrl
    import cmp_seq_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    output logic                        busy,
    output logic                        done,
    output logic                        eq,
    output logic                        gt,
    output logic                        lt
);

    localparam int IDX_W = idx_width(NIBBLES);
    localparam int OP_W  = NIBBLE_W * NIBBLES;

    state_e                 state_r;
    logic [IDX_W-1:0]       idx_r;
    logic [OP_W-1:0]        a_r;
    logic [OP_W-1:0]        b_r;
    logic [NIBBLE_W-1:0]    a_nib_s;
    logic [NIBBLE_W-1:0]    b_nib_s;
    logic                   nib_eq_s;
    logic                   nib_gt_s;
    logic                   nib_lt_s;

    // Select the nibble pair currently addressed by the index.
    always_comb begin
        a_nib_s = a_r[{idx_r, 2'b00} +: NIBBLE_W];
        b_nib_s = b_r[{idx_r, 2'b00} +: NIBBLE_W];
    end

    // Cascade is tied to "equal"; all combining across nibbles happens in the FSM.
    comparator4 u_cmp (
        .a     (a_nib_s),
        .b     (b_nib_s),
        .eq_in (1'b1),
        .gt_in (1'b0),
        .lt_in (1'b0),
        .eq    (nib_eq_s),
        .gt    (nib_gt_s),
        .lt    (nib_lt_s)
    );

    // Sequencer FSM with registered handshake and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            a_r     <= {OP_W{1'b0}};
            b_r     <= {OP_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        idx_r   <= IDX_W'(NIBBLES - 1);
                        eq      <= 1'b0;
                        gt      <= 1'b0;
                        lt      <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= CMP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CMP: begin
                    if (!nib_eq_s) begin
                        gt      <= nib_gt_s;
                        lt      <= nib_lt_s;
                        eq      <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else if (idx_r == {IDX_W{1'b0}}) begin
                        eq      <= 1'b1;
                        gt      <= 1'b0;
                        lt      <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        idx_r   <= idx_r - IDX_W'(1);
                        done    <= 1'b0;
                        state_r <= CMP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
